mem_stage: RTL and testbench

Memory-stage unit of the pipelined RV32I core, sitting between the Execute/Memory pipeline register and the register-file writeback. It consumes the M-stage control/data bundle, runs a request/response handshake to data memory, and stalls upstream stages while an access is outstanding. It registers the M→W boundary, including load data.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/load_align.sv | 50 +++++
 rtl/mem_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the RV32I memory stage: FSM state encoding, the
// funct3 load/store size codes and the byte-enable width.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int BE_WIDTH = 4;

  // Access size from funct3: 0 = byte, 1 = halfword, 2/3 = word
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load lane select and extension. Picks the byte/halfword at
// the given byte offset of the read word and sign- or zero-extends it
// according to funct3. Word loads (and any other code) pass rdata through.
//
// Ports:
//   offset  in  2   byte offset of the access within the word
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   rdata   in  32  raw word from data memory
//   result  out 32  aligned and extended load value
// ---------------------------------------------------------------------------
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first); a missed path would infer a latch.
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = rdata[15:0];
    case (offset)
      2'd0: begin byte_sel = rdata[7:0];   half_sel = rdata[15:0];  end
      2'd1: begin byte_sel = rdata[15:8];  half_sel = rdata[23:8];  end
      2'd2: begin byte_sel = rdata[23:16]; half_sel = rdata[31:16]; end
      // A halfword at offset 3 is misaligned and never issued.
      default: begin byte_sel = rdata[31:24]; half_sel = rdata[31:16]; end
    endcase
  end

  always_comb begin
    result = rdata;
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LBU:     result = {24'b0, byte_sel};
      LHU:     result = {16'b0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the pipelined RV32I core. Issues data-memory requests for
// loads/stores in M, stalls upstream while an access is outstanding, and
// registers the M->W boundary including load data.
//
// Build option:
//   MEMSTAGE_SUBWORD_EN  defined   -> byte/halfword accesses via funct3M,
//                                     lane-shifted dmem_be/dmem_wdata,
//                                     sign/zero-extended loads.
//                        undefined -> word-only, dmem_be = 4'b1111.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   validM .. PCPlus4M              M-stage bundle
//   stallM                          hold for IF/ID/EX/M registers
//   dmem_req/we/addr/wdata/be       request to data memory (combinational)
//   dmem_ready/rvalid/rdata         memory accept / response
//   validW .. PCPlus4W, misalignW   registered W-stage bundle
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // M stage
  input  logic                     validM,
  input  logic                     RegWriteM,
  input  logic                     ResultSrcM,
  input  logic                     MemWriteM,
  input  logic                     JumpM,
  input  logic [2:0]               funct3M,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  input  logic [DATA_WIDTH-1:0]    WriteDataM,
  input  logic [4:0]               RdM,
  input  logic [DATA_WIDTH-1:0]    PCPlus4M,
  // stall
  output logic                     stallM,
  // data memory
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [BE_WIDTH-1:0]      dmem_be,
  input  logic                     dmem_ready,
  input  logic                     dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  // W stage
  output logic                     validW,
  output logic                     RegWriteW,
  output logic                     ResultSrcW,
  output logic                     JumpW,
  output logic [4:0]               RdW,
  output logic [DATA_WIDTH-1:0]    ALUResultW,
  output logic [DATA_WIDTH-1:0]    ReadDataW,
  output logic [DATA_WIDTH-1:0]    PCPlus4W,
  output logic                     misalignW
);

  state_t          state, state_next;
  logic [1:0]      offset;
  logic            is_mem;
  logic            misaligned;
  logic            pending;
  logic            mis_access;
  logic            load_accept;
  logic [1:0]      align_offset;
  logic [2:0]      align_funct3;
  logic [31:0]     load_data;

  assign offset      = ALUResultM[1:0];
  assign is_mem      = MemWriteM | ResultSrcM;
  assign pending     = validM & is_mem & ~misaligned;
  assign mis_access  = validM & is_mem & misaligned;
  assign load_accept = (state == IDLE) & pending & ~MemWriteM & dmem_ready;

  assign dmem_addr = ADDRESS_WIDTH'({ALUResultM[DATA_WIDTH-1:2], 2'b00});

`ifdef MEMSTAGE_SUBWORD_EN
  logic [1:0] cap_offset;
  logic [2:0] cap_funct3;

  always_comb begin
    case (access_size(funct3M))
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = (offset == 2'd3);
      default: misaligned = (offset != 2'd0);
    endcase
  end

  // Store lanes: mask the store data to its size, then shift into place.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    case (access_size(funct3M))
      2'd0: begin
        dmem_be    = 4'b0001 << offset;
        dmem_wdata = {24'b0, WriteDataM[7:0]} << {offset, 3'b000};
      end
      2'd1: begin
        dmem_be    = 4'b0011 << offset;
        dmem_wdata = {16'b0, WriteDataM[15:0]} << {offset, 3'b000};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
      end
    endcase
  end

  // Offset and type are captured when the load is accepted so the response
  // is aligned against the issuing instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_offset <= 2'd0;
      cap_funct3 <= LW;
    end else if (load_accept) begin
      cap_offset <= offset;
      cap_funct3 <= funct3M;
    end
  end

  assign align_offset = cap_offset;
  assign align_funct3 = cap_funct3;
`else
  // funct3M has no effect in the word-only build.
  logic unused_funct3;
  assign unused_funct3 = ^funct3M;

  assign misaligned   = (offset != 2'd0);
  assign dmem_be      = 4'b1111;
  assign dmem_wdata   = WriteDataM;
  assign align_offset = 2'd0;
  assign align_funct3 = LW;
`endif

  load_align u_load_align (
    .offset (align_offset),
    .funct3 (align_funct3),
    .rdata  (dmem_rdata),
    .result (load_data)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (load_accept) state_next = WAIT_RSP;
      WAIT_RSP: if (dmem_rvalid) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    stallM   = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          dmem_req = 1'b1;
          dmem_we  = MemWriteM;
          // Only a store accepted this cycle completes without stalling.
          stallM   = ~(MemWriteM & dmem_ready);
        end
      end
      WAIT_RSP: stallM = ~dmem_rvalid;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // M->W register: advance when not stalled, insert a bubble otherwise.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      JumpW      <= 1'b0;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      misalignW  <= 1'b0;
    end else if (stallM) begin
      validW    <= 1'b0;
      RegWriteW <= 1'b0;
    end else begin
      validW     <= validM;
      RegWriteW  <= validM & RegWriteM & ~mis_access;
      ResultSrcW <= ResultSrcM;
      JumpW      <= JumpM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      misalignW  <= mis_access;
      // Unstalled in WAIT_RSP means the response is present this cycle.
      if (state == WAIT_RSP) ReadDataW <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed, table-driven bench for mem_stage. Each table row is one clock
// cycle: M inputs and memory responses, the expected combinational request
// outputs, and the expected W register contents after the edge. Hand-written
// sequences cover the backpressured store and reset during a pending load.
// ---------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        validM, RegWriteM, ResultSrcM, MemWriteM, JumpM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        stallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        validW, RegWriteW, ResultSrcW, JumpW, misalignW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .validM     (validM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .JumpM      (JumpM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .stallM     (stallM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ready (dmem_ready),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .validW     (validW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .JumpW      (JumpW),
    .RdW        (RdW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .misalignW  (misalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, rw, rs, mw, j;
    logic [2:0]  f3;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic        rdy, rv;
    logic [31:0] rdat;
    logic        e_req, e_stall;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_vw, e_rww, e_mis, chk_rd;
    logic [31:0] e_rdw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic v, rw, rs, mw, j, input logic [2:0] f3,
    input logic [31:0] alu, wd, input logic [4:0] rd,
    input logic rdy, rv, input logic [31:0] rdat,
    input logic e_req, e_stall, input logic [3:0] e_be, input logic [31:0] e_wd,
    input logic e_vw, e_rww, e_mis, chk_rd, input logic [31:0] e_rdw);
    vec_t t;
    t.v = v; t.rw = rw; t.rs = rs; t.mw = mw; t.j = j; t.f3 = f3;
    t.alu = alu; t.wd = wd; t.rd = rd; t.rdy = rdy; t.rv = rv; t.rdat = rdat;
    t.e_req = e_req; t.e_stall = e_stall; t.e_be = e_be; t.e_wd = e_wd;
    t.e_vw = e_vw; t.e_rww = e_rww; t.e_mis = e_mis; t.chk_rd = chk_rd;
    t.e_rdw = e_rdw;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t, input logic [31:0] pc4);
    validM     = t.v;
    RegWriteM  = t.rw;
    ResultSrcM = t.rs;
    MemWriteM  = t.mw;
    JumpM      = t.j;
    funct3M    = t.f3;
    ALUResultM = t.alu;
    WriteDataM = t.wd;
    RdM        = t.rd;
    PCPlus4M   = pc4;
    dmem_ready = t.rdy;
    dmem_rvalid = t.rv;
    dmem_rdata = t.rdat;
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, " validW"},     validW,     0);
    check({tag, " RegWriteW"},  RegWriteW,  0);
    check({tag, " ResultSrcW"}, ResultSrcW, 0);
    check({tag, " JumpW"},      JumpW,      0);
    check({tag, " RdW"},        RdW,        0);
    check({tag, " ALUResultW"}, ALUResultW, 0);
    check({tag, " ReadDataW"},  ReadDataW,  0);
    check({tag, " PCPlus4W"},   PCPlus4W,   0);
    check({tag, " misalignW"},  misalignW,  0);
  endtask

  // Safety net: the bench only waits on clock edges, but never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t zero;
    zero = mk(0,0,0,0,0,3'd0,0,0,0, 0,0,0, 0,0,4'hF,0, 0,0,0,0,0);

    // ---------------- table --------------------------------------------
    //        v rw rs mw j f3   alu            wd             rd  rdy rv rdata          | req stall be       wdata         | vW rwW mis chk rdW
    vecs.push_back(mk(1,1,0,0,0,3'd0,32'h0000_1234,32'h0,          5, 0,0,32'h0,          0,0,4'hF,   32'h0,         1,1,0,0,32'h0));
    vecs.push_back(mk(1,1,0,0,1,3'd0,32'h0000_2001,32'h0,          1, 0,0,32'h0,          0,0,4'hF,   32'h0,         1,1,0,0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,3'd0,32'h0000_0055,32'h0,          0, 0,0,32'h0,          0,0,4'hF,   32'h0,         0,0,0,0,32'h0));
    // LW 0x100, zero-wait memory
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0100,32'h0,          7, 1,0,32'h0,          1,1,4'hF,   32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0100,32'h0,          7, 0,1,32'hDEAD_BEEF,  0,0,4'hF,   32'h0,         1,1,0,1,32'hDEAD_BEEF));
    // SW accepted in the same cycle
    vecs.push_back(mk(1,0,0,1,0,SW,  32'h0000_0104,32'hCAFE_F00D,  0, 1,0,32'h0,          1,0,4'hF,   32'hCAFE_F00D, 1,0,0,0,32'h0));
    // LW with one ready-low cycle and one rvalid delay cycle
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0200,32'h0,          9, 0,0,32'h0,          1,1,4'hF,   32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0200,32'h0,          9, 1,0,32'h0,          1,1,4'hF,   32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0200,32'h0,          9, 0,0,32'h0,          0,1,4'hF,   32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0200,32'h0,          9, 0,1,32'h1234_5678,  0,0,4'hF,   32'h0,         1,1,0,1,32'h1234_5678));
    // rvalid while idle is ignored: ReadDataW holds
    vecs.push_back(mk(1,1,0,0,0,3'd0,32'h0000_3000,32'h0,          3, 0,1,32'h0000_FFFF,  0,0,4'hF,   32'h0,         1,1,0,1,32'h1234_5678));
    // LW at 0x102: misaligned, no request, retires with misalignW
    vecs.push_back(mk(1,1,1,0,0,LW,  32'h0000_0102,32'h0,          4, 1,0,32'h0,          0,0,4'hF,   32'h0,         1,0,1,0,32'h0));
    vecs.push_back(mk(1,1,0,0,0,3'd0,32'h0000_0010,32'h0,          6, 0,0,32'h0,          0,0,4'hF,   32'h0,         1,1,0,0,32'h0));
`ifdef MEMSTAGE_SUBWORD_EN
    // LB / LBU at 0x103
    vecs.push_back(mk(1,1,1,0,0,LB,  32'h0000_0103,32'h0,         10, 1,0,32'h0,          1,1,4'b1000,32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LB,  32'h0000_0103,32'h0,         10, 0,1,32'h80FF_FFFF,  0,0,4'hF,   32'h0,         1,1,0,1,32'hFFFF_FF80));
    vecs.push_back(mk(1,1,1,0,0,LBU, 32'h0000_0103,32'h0,         11, 1,0,32'h0,          1,1,4'b1000,32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LBU, 32'h0000_0103,32'h0,         11, 0,1,32'h80FF_FFFF,  0,0,4'hF,   32'h0,         1,1,0,1,32'h0000_0080));
    // SH 0xABCD at 0x102
    vecs.push_back(mk(1,0,0,1,0,SH,  32'h0000_0102,32'h1234_ABCD,  0, 1,0,32'h0,          1,0,4'b1100,32'hABCD_0000, 1,0,0,0,32'h0));
    // LH at offset 3 is misaligned
    vecs.push_back(mk(1,1,1,0,0,LH,  32'h0000_0103,32'h0,         13, 1,0,32'h0,          0,0,4'hF,   32'h0,         1,0,1,0,32'h0));
    // LHU at offset 1: bytes 1..2
    vecs.push_back(mk(1,1,1,0,0,LHU, 32'h0000_0101,32'h0,         12, 1,0,32'h0,          1,1,4'b0110,32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LHU, 32'h0000_0101,32'h0,         12, 0,1,32'h118A_BC22,  0,0,4'hF,   32'h0,         1,1,0,1,32'h0000_8ABC));
    // SB 0x5A at 0x101
    vecs.push_back(mk(1,0,0,1,0,SB,  32'h0000_0101,32'hFFFF_FF5A,  0, 1,0,32'h0,          1,0,4'b0010,32'h0000_5A00, 1,0,0,0,32'h0));
`else
    // Word-only: funct3 ignored, full word, all lanes
    vecs.push_back(mk(1,1,1,0,0,LB,  32'h0000_0100,32'h0,         10, 1,0,32'h0,          1,1,4'hF,   32'h0,         0,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LB,  32'h0000_0100,32'h0,         10, 0,1,32'h80FF_FFFF,  0,0,4'hF,   32'h0,         1,1,0,1,32'h80FF_FFFF));
    vecs.push_back(mk(1,0,0,1,0,SH,  32'h0000_0108,32'h1234_ABCD,  0, 1,0,32'h0,          1,0,4'hF,   32'h1234_ABCD, 1,0,0,0,32'h0));
    vecs.push_back(mk(1,1,1,0,0,LB,  32'h0000_0103,32'h0,         13, 1,0,32'h0,          0,0,4'hF,   32'h0,         1,0,1,0,32'h0));
`endif

    // ---------------- reset --------------------------------------------
    rst_n = 1'b0;
    drive(zero, 32'h0);
    #8;
    check("reset dmem_req", dmem_req, 0);
    check("reset dmem_we",  dmem_we,  0);
    check("reset stallM",   stallM,   0);
    check_w_zero("reset");
    #4 rst_n = 1'b1;

    // ---------------- table-driven vectors -----------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      logic [31:0] pc4;
      t   = vecs[i];
      pc4 = 32'h0000_1000 + 32'(i * 4);
      @(negedge clk);
      drive(t, pc4);
      #1;
      check($sformatf("v%0d dmem_req", i),  dmem_req,  t.e_req);
      check($sformatf("v%0d dmem_we", i),   dmem_we,   t.e_req & t.mw);
      check($sformatf("v%0d stallM", i),    stallM,    t.e_stall);
      check($sformatf("v%0d dmem_addr", i), dmem_addr, {t.alu[31:2], 2'b00});
      if (t.e_req) begin
        check($sformatf("v%0d dmem_be", i),    dmem_be,    t.e_be);
        check($sformatf("v%0d dmem_wdata", i), dmem_wdata, t.e_wd);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d validW", i),    validW,    t.e_vw);
      check($sformatf("v%0d RegWriteW", i), RegWriteW, t.e_rww);
      if (t.e_vw) begin
        check($sformatf("v%0d RdW", i),        RdW,        t.rd);
        check($sformatf("v%0d ALUResultW", i), ALUResultW, t.alu);
        check($sformatf("v%0d PCPlus4W", i),   PCPlus4W,   pc4);
        check($sformatf("v%0d JumpW", i),      JumpW,      t.j);
        check($sformatf("v%0d ResultSrcW", i), ResultSrcW, t.rs);
        check($sformatf("v%0d misalignW", i),  misalignW,  t.e_mis);
      end
      if (t.chk_rd)
        check($sformatf("v%0d ReadDataW", i), ReadDataW, t.e_rdw);
    end

    // ---------------- SW at 0x104 with ready low for 3 cycles ----------
    begin
      int req_cnt;
      int stall_cnt;
      req_cnt   = 0;
      stall_cnt = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        drive(mk(1,0,0,1,0,SW,32'h0000_0104,32'h0BAD_CAFE,0, (c == 3),0,32'h0,
                 0,0,4'hF,0, 0,0,0,0,0), 32'h0000_2000);
        #1;
        if (dmem_req) req_cnt++;
        if (stallM)   stall_cnt++;
        check($sformatf("sw c%0d dmem_req", c),   dmem_req,   1);
        check($sformatf("sw c%0d dmem_addr", c),  dmem_addr,  32'h0000_0104);
        check($sformatf("sw c%0d dmem_wdata", c), dmem_wdata, 32'h0BAD_CAFE);
        @(posedge clk);
        #1;
        check($sformatf("sw c%0d validW", c), validW, (c == 3));
      end
      check("sw req cycles",   req_cnt,   4);
      check("sw stall cycles", stall_cnt, 3);
      // Following instruction flows straight through: no trailing bubble.
      @(negedge clk);
      drive(mk(1,1,0,0,0,3'd0,32'h0000_0044,0,8, 0,0,0, 0,0,4'hF,0, 0,0,0,0,0), 32'h0000_2004);
      #1;
      check("sw next stallM", stallM, 0);
      @(posedge clk);
      #1;
      check("sw next validW", validW, 1);
      check("sw next RdW",    RdW,    8);
    end

    // ---------------- reset while waiting for a load response ----------
    @(negedge clk);
    drive(mk(1,1,1,0,0,LW,32'h0000_0300,0,14, 1,0,0, 0,0,4'hF,0, 0,0,0,0,0), 32'h0000_3000);
    @(posedge clk);
    #1;
    check("rst wait stallM",   stallM,   1);
    check("rst wait dmem_req", dmem_req, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(zero, 32'h0);
    #1;
    check_w_zero("rst asserted");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst release stallM",   stallM,   0);
    check("rst release dmem_req", dmem_req, 0);
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("late rsp stallM", stallM, 0);
    @(posedge clk);
    #1;
    check_w_zero("late rsp");
    @(negedge clk);
    drive(zero, 32'h0);
    @(posedge clk);
    #1;
    check_w_zero("after late rsp");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
